// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: requester and DRAM command/response signals shared by the arbiter and its users.
interface dram_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]                 i_req, i_we, o_gnt, o_rvalid;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_addr;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_wdata;
    logic [DATA_WIDTH-1:0]                  o_rdata, o_dram_wdata, i_dram_rdata;
    logic [ADDR_WIDTH-1:0]                  o_dram_addr;
    logic                                   o_busy, o_dram_req, o_dram_we, i_dram_ready;
    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_dram_ready, i_dram_rdata,
        output o_gnt, o_rvalid, o_rdata, o_busy, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata
    );
    modport master (
        output i_req, i_we, i_addr, i_wdata, i_dram_ready, i_dram_rdata,
        input  o_gnt, o_rvalid, o_rdata, o_busy, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata
    );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter giving several requesters single-outstanding access to one DRAM port.
module dram_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RD_LATENCY  = 2
) (
    input logic clk,
    input logic rst,
    dram_arbiter_if.slave bus
);
    localparam int PW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
    localparam logic [PW:0] NM = (PW+1)'(NUM_MASTERS);
    localparam logic [PW-1:0] LAST = PW'(NUM_MASTERS - 1);
    localparam logic [3:0] LAT = 4'(RD_LATENCY);
    localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d, owner_q, owner_d, off, sel;
    logic                   we_q, we_d, issue, accept;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d, rot;
    logic [PW:0]            sum;

    assign issue  = state_q == ISSUE;
    assign accept = issue && bus.i_dram_ready;

    // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
    always_comb begin
        rot = NUM_MASTERS'({bus.i_req, bus.i_req} >> ptr_q);
        off = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) off = rot[k] ? PW'(k) : off;
        sum = {1'b0, ptr_q} + {1'b0, off};
        sel = sum >= NM ? PW'(sum - NM) : PW'(sum);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;
        case (state_q)
            IDLE: if (|bus.i_req) begin
                owner_d = sel;
                we_d    = bus.i_we[sel];
                addr_d  = bus.i_addr[sel];
                wdata_d = bus.i_wdata[sel];
                state_d = ISSUE;
            end
            ISSUE: if (bus.i_dram_ready) begin
                ptr_d   = owner_q == LAST ? '0 : owner_q + PW'(1);
                state_d = we_q ? IDLE : WAIT_RD;
                cnt_d   = we_q ? cnt_q : 4'd1;
            end
            WAIT_RD: if (cnt_q == LAT) begin
                rdata_d  = bus.i_dram_rdata;
                rvalid_d = ONE << owner_q;
                cnt_d    = '0;
                state_d  = IDLE;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.o_busy       = state_q != IDLE;
    assign bus.o_dram_req   = issue;
    assign bus.o_dram_we    = issue & we_q;
    assign bus.o_dram_addr  = issue ? addr_q : '0;
    assign bus.o_dram_wdata = issue ? wdata_q : '0;
    assign bus.o_gnt        = accept ? ONE << owner_q : '0;
    assign bus.o_rvalid     = rvalid_q;
    assign bus.o_rdata      = rdata_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: table-driven and sequence tests of dram_arbiter with a grant/read-data scoreboard.
module tb_dram_arbiter;
    localparam int NM = 3, AW = 32, DW = 32, RDL = 2;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    dram_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    dram_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    typedef struct {int mst; logic we; logic [31:0] addr; logic [31:0] wdata; int cyc;} gnt_t;
    typedef struct {int mst; logic [31:0] data;} rd_t;
    typedef struct {int mst; logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; int stall;} vec_t;

    gnt_t gq[$];
    rd_t  rq[$];
    gnt_t ge;
    rd_t  re;
    vec_t vecs[6];
    int checks = 0, failures = 0, cyc = 0, acc_cyc = -100, t;
    logic [31:0] rd_val = '0;
    logic ok;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int m, logic we, logic [31:0] a, logic [31:0] d);
        bus.i_we[m] = we;
        bus.i_addr[m] = a;
        bus.i_wdata[m] = d;
        bus.i_req[m] = 1'b1;
    endtask

    task automatic wait_gnt(int m);
        repeat (50) begin
            @(negedge clk);
            if (bus.o_gnt[m]) return;
        end
        checks++;
        failures++;
        $display("FAIL gnt_timeout: master %0d got no grant, required one", m);
    endtask

    task automatic wait_idle();
        repeat (50) begin
            tick();
            if (!bus.o_busy && gq.size() == 0 && rq.size() == 0) return;
        end
        checks++;
        failures++;
        $display("FAIL idle_timeout: busy=%0b pending gnt=%0d rd=%0d, required all 0", bus.o_busy, gq.size(), rq.size());
    endtask

    task automatic run_vec(vec_t v);
        gq.push_back('{v.mst, v.we, v.addr, v.wdata, cyc + 1 + v.stall});
        if (!v.we) begin
            rq.push_back('{v.mst, v.rdata});
            rd_val = v.rdata;
        end
        bus.i_dram_ready = 1'b0;
        drive(v.mst, v.we, v.addr, v.wdata);
        tick();
        repeat (v.stall) tick();
        bus.i_dram_ready = 1'b1;
        wait_gnt(v.mst);
        tick();
        bus.i_req = '0;
        wait_idle();
    endtask

    // DRAM model: read data is only correct in the cycle RD_LATENCY after acceptance.
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 bus.i_dram_rdata = (cyc == acc_cyc + RDL) ? rd_val : 32'hDEADBEEF;
    end

    always @(negedge clk) begin
        if (|bus.o_gnt || |bus.o_rvalid) begin
            ok = ($onehot(bus.o_gnt) && bus.o_rvalid == '0) || (bus.o_gnt == '0 && $onehot(bus.o_rvalid));
            chk("gnt_rvalid_onehot_excl", {63'd0, ok}, 64'd1);
        end
        if (|bus.o_gnt) begin
            if (!bus.o_dram_we) acc_cyc = cyc;
            if (gq.size() == 0) chk("gnt_unexpected", bus.o_gnt, 0);
            else begin
                ge = gq.pop_front();
                chk("gnt", bus.o_gnt, 3'b1 << ge.mst);
                chk("gnt_cycle", cyc, ge.cyc);
                chk("dram_we", bus.o_dram_we, ge.we);
                chk("dram_addr", bus.o_dram_addr, ge.addr);
                chk("dram_wdata", bus.o_dram_wdata, ge.wdata);
            end
        end
        if (|bus.o_rvalid) begin
            if (rq.size() == 0) chk("rvalid_unexpected", bus.o_rvalid, 0);
            else begin
                re = rq.pop_front();
                chk("rvalid", bus.o_rvalid, 3'b1 << re.mst);
                chk("rdata", bus.o_rdata, re.data);
                chk("rvalid_cycle", cyc, acc_cyc + RDL + 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 1'b0, 32'h100,      32'h0,        32'hCAFEF00D, 0};
        vecs[1] = '{0, 1'b1, 32'h200,      32'h11112222, 32'h0,        0};
        vecs[2] = '{2, 1'b0, 32'h300,      32'h5A5A0000, 32'h12345678, 2};
        vecs[3] = '{1, 1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5, 32'h0,        1};
        vecs[4] = '{2, 1'b1, 32'h0,        32'hFFFFFFFF, 32'h0,        0};
        vecs[5] = '{0, 1'b0, 32'h4,        32'h0,        32'h0BADBEEF, 0};

        bus.i_req = '1;
        bus.i_we = 3'b010;
        bus.i_addr = '{32'h30, 32'h20, 32'h10};
        bus.i_wdata = '{32'h3, 32'h2, 32'h1};
        bus.i_dram_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_dram_req", bus.o_dram_req, 0);
        chk("rst_gnt", bus.o_gnt, 0);
        tick();
        rst = 1'b0;
        bus.i_req = '0;
        @(negedge clk);
        chk("rel_busy", bus.o_busy, 0);
        chk("rel_dram_req", bus.o_dram_req, 0);
        chk("rel_dram_we", bus.o_dram_we, 0);
        chk("rel_dram_addr", bus.o_dram_addr, 0);
        chk("rel_dram_wdata", bus.o_dram_wdata, 0);
        chk("rel_rvalid", bus.o_rvalid, 0);
        chk("rel_rdata", bus.o_rdata, 0);

        // Contention: all write continuously, grants rotate 0,1,2,0 every other cycle
        tick();
        t = cyc;
        for (int m = 0; m < NM; m++) drive(m, 1'b1, 32'(32'h1000 + m * 16), 32'(32'hA0 + m));
        gq.push_back('{0, 1'b1, 32'h1000, 32'hA0, t + 1});
        gq.push_back('{1, 1'b1, 32'h1010, 32'hA1, t + 3});
        gq.push_back('{2, 1'b1, 32'h1020, 32'hA2, t + 5});
        gq.push_back('{0, 1'b1, 32'h1000, 32'hA0, t + 7});
        repeat (7) tick();
        @(negedge clk);
        tick();
        bus.i_req = '0;
        wait_idle();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Backpressure: master 2 stalled five cycles
        t = cyc;
        gq.push_back('{2, 1'b1, 32'h40, 32'h55, t + 6});
        bus.i_dram_ready = 1'b0;
        drive(2, 1'b1, 32'h40, 32'h55);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 6) bus.i_dram_ready = 1'b1;
            @(negedge clk);
            chk("bp_dram_req", bus.o_dram_req, 1);
            chk("bp_dram_addr", bus.o_dram_addr, 32'h40);
            chk("bp_dram_wdata", bus.o_dram_wdata, 32'h55);
            if (i < 6) chk("bp_gnt", bus.o_gnt, 0);
        end
        tick();
        bus.i_req = '0;
        wait_idle();

        // Wrap: pointer now 0 after master 2, so 0 beats 2
        t = cyc;
        drive(0, 1'b1, 32'h60, 32'h600);
        drive(2, 1'b1, 32'h62, 32'h622);
        gq.push_back('{0, 1'b1, 32'h60, 32'h600, t + 1});
        gq.push_back('{2, 1'b1, 32'h62, 32'h622, t + 3});
        tick();
        @(negedge clk);
        tick();
        bus.i_req[0] = 1'b0;
        @(negedge clk);
        tick();
        bus.i_req = '0;
        wait_idle();

        // Reset during a stalled ISSUE abandons the command
        bus.i_dram_ready = 1'b0;
        drive(0, 1'b1, 32'h70, 32'h7);
        tick();
        rst = 1'b1;
        bus.i_req = '0;
        tick();
        rst = 1'b0;
        bus.i_dram_ready = 1'b1;
        @(negedge clk);
        chk("rst_issue_dram_req", bus.o_dram_req, 0);
        chk("rst_issue_busy", bus.o_busy, 0);
        repeat (3) tick();

        // Reset in the cycle after a read grant: no rvalid afterwards, pointer back to 0
        tick();
        t = cyc;
        rd_val = 32'h77777777;
        gq.push_back('{1, 1'b0, 32'h500, 32'h0, t + 1});
        drive(1, 1'b0, 32'h500, 32'h0);
        tick();
        @(negedge clk);
        tick();
        rst = 1'b1;
        bus.i_req = '0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_busy", bus.o_busy, 0);
        chk("rst_rd_rdata", bus.o_rdata, 0);
        repeat (10) tick();
        t = cyc;
        drive(1, 1'b1, 32'h80, 32'h8);
        drive(2, 1'b1, 32'h90, 32'h9);
        gq.push_back('{1, 1'b1, 32'h80, 32'h8, t + 1});
        gq.push_back('{2, 1'b1, 32'h90, 32'h9, t + 3});
        tick();
        @(negedge clk);
        tick();
        bus.i_req[1] = 1'b0;
        @(negedge clk);
        tick();
        bus.i_req = '0;
        wait_idle();

        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            chk("idle_busy", bus.o_busy, 0);
            chk("idle_dram_req", bus.o_dram_req, 0);
            chk("idle_gnt", bus.o_gnt, 0);
            chk("idle_rvalid", bus.o_rvalid, 0);
        end

        chk("gnt_queue_drained", gq.size(), 0);
        chk("rd_queue_drained", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
